mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// Memory stage directly downstream of the execute datapath. Accepts one LDR/STR per
// handshake, using the datapath result as the byte address and str_data as store data.
// Drives a req/ack data-memory port and returns load data to the regfile LDR write port
// (w_data_ldr/w_addr_ldr/w_en_ldr). Stalls upstream while a transfer is in flight.
// PARAMETERS
// ADDR_W  11  byte-address width driven to data memory (mem_addr = addr_q[ADDR_W-1:0])
// PORTS
// clk          in   1       rising-edge clock
// rst_n        in   1       asynchronous active-low reset
// in_valid     in   1       execute stage presents an op this cycle
// in_ready     out  1       stage can accept (1 only in IDLE)
// is_ldr       in   1       op is a load
// is_str       in   1       op is a store
// rd_addr      in   4       load destination register
// addr_in      in   32      effective byte address (datapath_out)
// str_data_in  in   32      store data (regfile str_data)
// byte_op      in   1       byte access; used only with MEM_BYTE_ACCESS_EN
// mem_req      out  1       memory request, held until mem_ack
// mem_we       out  1       1 = write, 0 = read; valid while mem_req
// mem_addr     out  ADDR_W  byte address; [1:0] forced 0 for word access
// mem_wdata    out  32      write data
// mem_be       out  4       byte enables (4'b1111 for word access)
// mem_rdata    in   32      read data, valid in the cycle mem_ack=1
// mem_ack      in   1       completes the request; ignored when mem_req=0
// w_en_ldr     out  1       one-cycle pulse: write w_data_ldr to w_addr_ldr
// w_addr_ldr   out  4       load destination
// w_data_ldr   out  32      load data
// stall        out  1       = ~in_ready; freezes PC and pipeline registers upstream
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; mem_req, mem_we, w_en_ldr=0; mem_addr, mem_wdata,
//   w_data_ldr=0; w_addr_ldr=0; mem_be=0; in_ready=1. Reset mid-transfer abandons the
//   request: no regfile write, mem_req drops asynchronously.
// - FSM IDLE -> REQ -> (WB) -> IDLE. All outputs registered except in_ready/stall (from state).
// - IDLE: accept when in_valid && (is_ldr || is_str). Latch addr, data, rd, op -> REQ.
//   in_valid with neither flag: no-op, stay IDLE. is_ldr && is_str: treated as LDR.
// - REQ: mem_req=1, mem_we=(op==STR). Inputs ignored. mem_ack=0 -> stay (unbounded wait).
//   mem_ack=1: STR -> IDLE; LDR -> capture mem_rdata into w_data_ldr -> WB.
// - WB: w_en_ldr=1 for exactly one cycle -> IDLE. Load result visible to forwarding
//   (w_data_ldr) in the WB cycle.
// - Latency with zero-wait memory (ack in first REQ cycle): STR accept@T, req@T+1,
//   ready@T+2; LDR accept@T, req@T+1, w_en_ldr@T+2, ready@T+3.
// - Address: addr_in[31:ADDR_W] discarded. Word access: mem_addr[1:0]=0, mem_be=4'b1111.
// - mem_rdata, mem_ack are don't-care outside REQ; a spurious ack in IDLE/WB has no effect.
// CONFIGURATION
// MEM_BYTE_ACCESS_EN defined: byte_op=1 -> mem_addr keeps addr[1:0]; mem_be one-hot on
//   addr[1:0]; STR replicates str_data_in[7:0] to all lanes; LDR zero-extends the selected
//   byte of mem_rdata into w_data_ldr[7:0].
// MEM_BYTE_ACCESS_EN undefined: byte_op ignored, all accesses are aligned words.
// TESTING
// 1 Reset: rst_n=0 mid-REQ -> mem_req=0 immediately, in_ready=1, no w_en_ldr pulse after.
// 2 STR addr=0x40 data=0xDEADBEEF, ack same cycle -> mem_we=1, mem_addr=0x40,
//   mem_be=4'hF, in_ready back at T+2, w_en_ldr never asserted.
// 3 LDR rd=5 addr=0x7C, ack after 3 wait cycles, rdata=0x12345678 -> stall 5 cycles,
//   single w_en_ldr pulse with w_addr_ldr=5, w_data_ldr=0x12345678.
// 4 LDR addr=0x0803 (word) -> mem_addr=0x000 (bit 11 dropped, [1:0] forced 0).
// 5 in_valid with is_ldr=is_str=0, and spurious mem_ack in IDLE -> no mem_req, no write.
// 6 MEM_BYTE_ACCESS_EN: LDRB addr=0x42, rdata=0xAABBCCDD -> mem_be=4'b0100,
//   w_data_ldr=0x000000BB; without macro same stimulus -> mem_addr=0x40, data=0xAABBCCDD.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge port of the memory access stage.
// The master side is the memory access unit and the slave side is the data memory.
`timescale 1ns/1ps
interface mem_access_unit_if #(
   parameter int ADDR_W = 11
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_be;
   logic [31:0]       mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      output mem_be,
      input  mem_rdata,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      input  mem_be,
      output mem_rdata,
      output mem_ack
   );
endinterface

// File: rtl/mem_access_unit.sv
// Memory stage: issues one LDR/STR per accepted op on a req/ack port and writes load data back.
// Optional byte access (byte_op) is compiled in with `define MEM_BYTE_ACCESS_EN.
`timescale 1ns/1ps
module mem_access_unit #(
   parameter int ADDR_W = 11
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   is_ldr,
   input  logic                   is_str,
   input  logic [3:0]             rd_addr,
   input  logic [31:0]            addr_in,
   input  logic [31:0]            str_data_in,
   input  logic                   byte_op,
   mem_access_unit_if.master      mem,
   output logic                   w_en_ldr,
   output logic [3:0]             w_addr_ldr,
   output logic [31:0]            w_data_ldr,
   output logic                   stall
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   state_t            state_r;
   logic              op_ldr_r;
   logic [3:0]        rd_r;
   logic              accept_s;
   logic [ADDR_W-1:0] addr_s;
   logic [3:0]        be_s;
   logic [31:0]       wdata_s;
   logic [31:0]       rdata_s;
   logic              unused_s;

`ifdef MEM_BYTE_ACCESS_EN
   logic              byte_r;
   logic [1:0]        lane_r;

   function automatic logic [31:0] byte_sel(input logic [31:0] word, input logic [1:0] lane);
      logic [31:0] res;
      case (lane)
         2'd0:    res = {24'h000000, word[7:0]};
         2'd1:    res = {24'h000000, word[15:8]};
         2'd2:    res = {24'h000000, word[23:16]};
         2'd3:    res = {24'h000000, word[31:24]};
         default: res = 32'h00000000;
      endcase
      return res;
   endfunction

   assign unused_s = ^addr_in[31:ADDR_W];
`else
   assign unused_s = ^{addr_in[31:ADDR_W], byte_op};
`endif

   assign accept_s = in_valid && (is_ldr || is_str);
   assign in_ready = (state_r == ST_IDLE);
   assign stall    = ~in_ready;

   // Request address, byte enables and write data derived from the incoming op
   always_comb begin
      addr_s  = addr_in[ADDR_W-1:0];
      be_s    = 4'b1111;
      wdata_s = str_data_in;
`ifdef MEM_BYTE_ACCESS_EN
      if (byte_op) begin
         be_s    = 4'b0001 << addr_in[1:0];
         wdata_s = {4{str_data_in[7:0]}};
      end else begin
         addr_s[1:0] = 2'b00;
      end
`else
      addr_s[1:0] = 2'b00;
`endif
   end

   // Load data as written back: whole word, or the zero-extended selected byte
   always_comb begin
      rdata_s = mem.mem_rdata;
`ifdef MEM_BYTE_ACCESS_EN
      if (byte_r) begin
         rdata_s = byte_sel(mem.mem_rdata, lane_r);
      end else begin
         rdata_s = mem.mem_rdata;
      end
`endif
   end

   // Transfer FSM with registered memory-port and writeback outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= ST_IDLE;
         op_ldr_r       <= 1'b0;
         rd_r           <= 4'h0;
         mem.mem_req    <= 1'b0;
         mem.mem_we     <= 1'b0;
         mem.mem_addr   <= '0;
         mem.mem_wdata  <= 32'h00000000;
         mem.mem_be     <= 4'b0000;
         w_en_ldr       <= 1'b0;
         w_addr_ldr     <= 4'h0;
         w_data_ldr     <= 32'h00000000;
`ifdef MEM_BYTE_ACCESS_EN
         byte_r         <= 1'b0;
         lane_r         <= 2'b00;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               w_en_ldr <= 1'b0;
               if (accept_s) begin
                  // A simultaneous LDR+STR flag pair resolves to a load
                  op_ldr_r      <= is_ldr;
                  rd_r          <= rd_addr;
                  mem.mem_req   <= 1'b1;
                  mem.mem_we    <= ~is_ldr;
                  mem.mem_addr  <= addr_s;
                  mem.mem_wdata <= wdata_s;
                  mem.mem_be    <= be_s;
`ifdef MEM_BYTE_ACCESS_EN
                  byte_r        <= byte_op;
                  lane_r        <= addr_in[1:0];
`endif
                  state_r       <= ST_REQ;
               end else begin
                  state_r       <= ST_IDLE;
               end
            end
            ST_REQ: begin
               if (mem.mem_ack) begin
                  mem.mem_req <= 1'b0;
                  mem.mem_we  <= 1'b0;
                  if (op_ldr_r) begin
                     w_data_ldr <= rdata_s;
                     w_addr_ldr <= rd_r;
                     w_en_ldr   <= 1'b1;
                     state_r    <= ST_WB;
                  end else begin
                     state_r    <= ST_IDLE;
                  end
               end else begin
                  state_r <= ST_REQ;
               end
            end
            ST_WB: begin
               w_en_ldr <= 1'b0;
               state_r  <= ST_IDLE;
            end
            default: begin
               mem.mem_req <= 1'b0;
               mem.mem_we  <= 1'b0;
               w_en_ldr    <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit: expected requests/writebacks are queued when
// ops are driven and checked when the DUT presents them.
`timescale 1ns/1ps
module tb_mem_access_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        is_ldr;
   logic        is_str;
   logic [3:0]  rd_addr;
   logic [31:0] addr_in;
   logic [31:0] str_data_in;
   logic        byte_op;
   logic        w_en_ldr;
   logic [3:0]  w_addr_ldr;
   logic [31:0] w_data_ldr;
   logic        stall;

   int total;
   int bad;
   int wen_cnt;
   int stalls;
   int w_before;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      logic [3:0]  rd;
      logic [31:0] data;
   } wb_t;

   req_t req_q[$];
   wb_t  wb_q[$];

   mem_access_unit_if #(.ADDR_W(11)) mif ();

   mem_access_unit #(.ADDR_W(11)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .is_ldr      (is_ldr),
      .is_str      (is_str),
      .rd_addr     (rd_addr),
      .addr_in     (addr_in),
      .str_data_in (str_data_in),
      .byte_op     (byte_op),
      .mem         (mif.master),
      .w_en_ldr    (w_en_ldr),
      .w_addr_ldr  (w_addr_ldr),
      .w_data_ldr  (w_data_ldr),
      .stall       (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count write-enable pulses, sampled mid-cycle
   always @(negedge clk) begin
      if (w_en_ldr === 1'b1) wen_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string tag, input logic ldr, input logic str,
                         input logic [3:0] rd, input logic [31:0] addr, input logic [31:0] data,
                         input logic bop, input int waits, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input logic [31:0] exp_wb,
                         output int nstall);
      req_t r;
      wb_t  w;
      int   n;
      int   w0;
      w0 = wen_cnt;
      nstall = 0;
      r.we = ~ldr; r.addr = exp_addr; r.be = exp_be; r.wdata = exp_wd;
      req_q.push_back(r);
      if (ldr) begin
         w.rd = rd; w.data = exp_wb;
         wb_q.push_back(w);
      end
      in_valid = 1'b1; is_ldr = ldr; is_str = str; rd_addr = rd;
      addr_in = addr; str_data_in = data; byte_op = bop;
      tick();
      in_valid = 1'b0; is_ldr = 1'b0; is_str = 1'b0;
      addr_in = $urandom; str_data_in = $urandom;
      n = 0;
      while (mif.mem_req !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      chk({tag, ".req_seen"}, {31'd0, mif.mem_req}, 32'd1);
      chk({tag, ".req_latency"}, n, 32'd0);
      r = req_q.pop_front();
      chk({tag, ".we"}, {31'd0, mif.mem_we}, {31'd0, r.we});
      chk({tag, ".addr"}, {21'd0, mif.mem_addr}, r.addr);
      chk({tag, ".be"}, {28'd0, mif.mem_be}, {28'd0, r.be});
      if (!ldr) chk({tag, ".wdata"}, mif.mem_wdata, r.wdata);
      for (int i = 0; i < waits; i++) begin
         if (stall === 1'b1) nstall++;
         tick();
         chk({tag, ".req_held"}, {31'd0, mif.mem_req}, 32'd1);
      end
      if (stall === 1'b1) nstall++;
      mif.mem_ack = 1'b1; mif.mem_rdata = rdata;
      tick();
      mif.mem_ack = 1'b0; mif.mem_rdata = $urandom;
      chk({tag, ".req_drop"}, {31'd0, mif.mem_req}, 32'd0);
      if (ldr) begin
         if (stall === 1'b1) nstall++;
         w = wb_q.pop_front();
         chk({tag, ".w_en"}, {31'd0, w_en_ldr}, 32'd1);
         chk({tag, ".w_addr"}, {28'd0, w_addr_ldr}, {28'd0, w.rd});
         chk({tag, ".w_data"}, w_data_ldr, w.data);
         tick();
         chk({tag, ".w_en_low"}, {31'd0, w_en_ldr}, 32'd0);
      end
      chk({tag, ".ready"}, {31'd0, in_ready}, 32'd1);
      chk({tag, ".pulses"}, wen_cnt - w0, ldr ? 32'd1 : 32'd0);
   endtask

   initial begin
      total = 0; bad = 0; wen_cnt = 0;
      rst_n = 1'b0; in_valid = 1'b0; is_ldr = 1'b0; is_str = 1'b0;
      rd_addr = 4'h0; addr_in = 32'h0; str_data_in = 32'h0; byte_op = 1'b0;
      mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
      tick();
      tick();
      chk("rst.mem_req", {31'd0, mif.mem_req}, 32'd0);
      chk("rst.mem_we", {31'd0, mif.mem_we}, 32'd0);
      chk("rst.mem_addr", {21'd0, mif.mem_addr}, 32'd0);
      chk("rst.mem_wdata", mif.mem_wdata, 32'd0);
      chk("rst.mem_be", {28'd0, mif.mem_be}, 32'd0);
      chk("rst.w_en", {31'd0, w_en_ldr}, 32'd0);
      chk("rst.w_addr", {28'd0, w_addr_ldr}, 32'd0);
      chk("rst.w_data", w_data_ldr, 32'd0);
      chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst.stall", {31'd0, stall}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Store, zero-wait ack
      run_op("str40", 1'b0, 1'b1, 4'd0, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 0, 32'h0,
             32'h040, 4'hF, 32'hDEAD_BEEF, 32'h0, stalls);
      chk("str40.stalls", stalls, 32'd1);

      // Load with three wait cycles
      run_op("ldr7c", 1'b1, 1'b0, 4'd5, 32'h0000_007C, 32'h0, 1'b0, 3, 32'h1234_5678,
             32'h07C, 4'hF, 32'h0, 32'h1234_5678, stalls);
      chk("ldr7c.stalls", stalls, 32'd5);

      // Word load: bit 11 dropped, low bits forced to zero
      run_op("ldr803", 1'b1, 1'b0, 4'd9, 32'h0000_0803, 32'h0, 1'b0, 0, 32'hCAFE_F00D,
             32'h000, 4'hF, 32'h0, 32'hCAFE_F00D, stalls);
      chk("ldr803.stalls", stalls, 32'd2);

      // Both flags set behaves as a load
      run_op("both", 1'b1, 1'b1, 4'd15, 32'hFFFF_F7FC, 32'h5555_AAAA, 1'b0, 1, 32'h0BAD_CAFE,
             32'h7FC, 4'hF, 32'h0, 32'h0BAD_CAFE, stalls);

      // No-op valid and spurious ack while idle
      w_before = wen_cnt;
      in_valid = 1'b1; addr_in = 32'h0000_0100; mif.mem_ack = 1'b1; mif.mem_rdata = 32'hFFFF_FFFF;
      tick();
      chk("noop.req", {31'd0, mif.mem_req}, 32'd0);
      chk("noop.ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0; mif.mem_ack = 1'b0;
      tick();
      chk("noop.req2", {31'd0, mif.mem_req}, 32'd0);
      chk("noop.pulses", wen_cnt - w_before, 32'd0);

`ifdef MEM_BYTE_ACCESS_EN
      run_op("ldrb42", 1'b1, 1'b0, 4'd3, 32'h0000_0042, 32'h0, 1'b1, 0, 32'hAABB_CCDD,
             32'h042, 4'b0100, 32'h0, 32'h0000_00BB, stalls);
      run_op("strb41", 1'b0, 1'b1, 4'd0, 32'h0000_0041, 32'h1122_3344, 1'b1, 2, 32'h0,
             32'h041, 4'b0010, 32'h4444_4444, 32'h0, stalls);
`else
      run_op("ldrb42", 1'b1, 1'b0, 4'd3, 32'h0000_0042, 32'h0, 1'b1, 0, 32'hAABB_CCDD,
             32'h040, 4'hF, 32'h0, 32'hAABB_CCDD, stalls);
      run_op("strb41", 1'b0, 1'b1, 4'd0, 32'h0000_0041, 32'h1122_3344, 1'b1, 2, 32'h0,
             32'h040, 4'hF, 32'h1122_3344, 32'h0, stalls);
`endif

      // Reset asserted while a load request is outstanding
      w_before = wen_cnt;
      in_valid = 1'b1; is_ldr = 1'b1; rd_addr = 4'd7; addr_in = 32'h0000_0010;
      tick();
      in_valid = 1'b0; is_ldr = 1'b0;
      chk("rstmid.req_before", {31'd0, mif.mem_req}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid.req_async", {31'd0, mif.mem_req}, 32'd0);
      chk("rstmid.ready", {31'd0, in_ready}, 32'd1);
      chk("rstmid.stall", {31'd0, stall}, 32'd0);
      mif.mem_ack = 1'b1; mif.mem_rdata = 32'h7777_7777;
      tick();
      rst_n = 1'b1;
      tick();
      mif.mem_ack = 1'b0;
      tick();
      tick();
      chk("rstmid.req_after", {31'd0, mif.mem_req}, 32'd0);
      chk("rstmid.pulses", wen_cnt - w_before, 32'd0);
      chk("rstmid.w_data", w_data_ldr, 32'd0);
      chk("sb.empty", req_q.size() + wb_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
